// File: rtl/timebase_controller_if.sv
// Command/status bundle between a run-control master and the timebase controller.
// Optional burst signals exist only when TIMEBASE_BURST_EN is defined.
interface timebase_controller_if;
  logic        start;
  logic        stop;
  logic        step;
  logic [1:0]  rate_sel;
  logic        tick;
  logic        sq_out;
  logic        busy;
  logic [15:0] tick_count;
  logic [1:0]  state;
`ifdef TIMEBASE_BURST_EN
  logic [7:0]  burst_len;
  logic        burst_done;

  modport master (
    output start, stop, step, rate_sel, burst_len,
    input  tick, sq_out, busy, tick_count, state, burst_done
  );
  modport slave (
    input  start, stop, step, rate_sel, burst_len,
    output tick, sq_out, busy, tick_count, state, burst_done
  );
`else
  modport master (
    output start, stop, step, rate_sel,
    input  tick, sq_out, busy, tick_count, state
  );
  modport slave (
    input  start, stop, step, rate_sel,
    output tick, sq_out, busy, tick_count, state
  );
`endif
endinterface

// File: rtl/timebase_controller.sv
// Run-control and rate scheduler for the lab timebase.
// One 32-bit divider counter serves three selectable rates; an FSM provides
// start/stop/single-step control. Rate changes take effect only at the end of
// a full sq_out period so tick spacing never glitches.
// Optional feature macro: TIMEBASE_BURST_EN (bounded tick bursts in RUN).
module timebase_controller #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned FREQ_SLOW  = 1,
  parameter int unsigned FREQ_MID   = 20,
  parameter int unsigned FREQ_FAST  = 500
) (
  input  logic                  clock,
  input  logic                  reset_n,
  timebase_controller_if.slave  bus
);

  localparam logic [31:0] HALF_SLOW = 32'(CLOCK_FREQ / (2 * FREQ_SLOW));
  localparam logic [31:0] HALF_MID  = 32'(CLOCK_FREQ / (2 * FREQ_MID));
  localparam logic [31:0] HALF_FAST = 32'(CLOCK_FREQ / (2 * FREQ_FAST));

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    STEP  = 2'b11
  } state_e;

  state_e      state_q;
  logic [31:0] counter_q;
  logic        sq_q;
  logic        tick_q;
  logic [15:0] tick_count_q;
  logic [1:0]  active_q;
  logic [1:0]  pending_q;
`ifdef TIMEBASE_BURST_EN
  logic [7:0]  burst_rem_q;
  logic        burst_on_q;
  logic        burst_done_q;
`endif

  logic [31:0] half_m1_d;
  logic        wrap_d;
  logic        rise_d;
  logic        fall_d;

  // Terminal count for the half period of the currently active rate
  always_comb begin
    half_m1_d = HALF_SLOW - 32'd1;
    case (active_q)
      2'b01:   half_m1_d = HALF_MID - 32'd1;
      2'b10:   half_m1_d = HALF_FAST - 32'd1;
      default: half_m1_d = HALF_SLOW - 32'd1;
    endcase
  end

  // wrap: sq_out toggles on this edge if counting; rise/fall give its direction
  assign wrap_d = (counter_q == half_m1_d);
  assign rise_d = wrap_d & ~sq_q;
  assign fall_d = wrap_d & sq_q;

  // Run-control FSM together with divider, square wave, tick and rate registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      sq_q         <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      active_q     <= 2'b00;
      pending_q    <= 2'b00;
`ifdef TIMEBASE_BURST_EN
      burst_rem_q  <= '0;
      burst_on_q   <= 1'b0;
      burst_done_q <= 1'b0;
`endif
    end else begin
      tick_q <= 1'b0;
`ifdef TIMEBASE_BURST_EN
      burst_done_q <= 1'b0;
`endif
      // 11 means "keep current"; anything else is the requested rate
      if (bus.rate_sel != 2'b11) begin
        pending_q <= bus.rate_sel;
      end

      case (state_q)
        IDLE: begin
          active_q  <= pending_q;
          counter_q <= '0;
          sq_q      <= 1'b0;
          if (!bus.stop && bus.start) begin
            state_q <= RUN;
`ifdef TIMEBASE_BURST_EN
            burst_rem_q <= bus.burst_len;
            burst_on_q  <= (bus.burst_len != 8'd0);
`endif
          end else if (!bus.stop && bus.step) begin
            state_q <= STEP;
          end
        end

        RUN: begin
`ifdef TIMEBASE_BURST_EN
          // Burst exhausted: the edge after the final tick returns to IDLE
          if (burst_on_q && (burst_rem_q == 8'd0)) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            sq_q         <= 1'b0;
            burst_on_q   <= 1'b0;
            burst_done_q <= 1'b1;
          end else
`endif
          if (bus.stop) begin
            // counter and sq_out hold their values while paused
            state_q <= PAUSE;
          end else begin
            counter_q <= wrap_d ? '0 : counter_q + 32'd1;
            if (wrap_d) begin
              sq_q <= ~sq_q;
            end
            if (rise_d) begin
              tick_q       <= 1'b1;
              tick_count_q <= tick_count_q + 16'd1;
`ifdef TIMEBASE_BURST_EN
              if (burst_on_q) begin
                burst_rem_q <= burst_rem_q - 8'd1;
              end
`endif
            end
            if (fall_d) begin
              active_q <= pending_q;
            end
          end
        end

        PAUSE: begin
          if (bus.stop) begin
            state_q   <= IDLE;
            counter_q <= '0;
            sq_q      <= 1'b0;
`ifdef TIMEBASE_BURST_EN
            burst_on_q <= 1'b0;
`endif
          end else if (bus.start) begin
            state_q <= RUN;
          end else if (bus.step) begin
            state_q <= STEP;
          end
        end

        STEP: begin
          // Leave on stop, or on the edge after the single tick (sq_out stays 1)
          if (bus.stop || tick_q) begin
            state_q <= PAUSE;
          end else begin
            counter_q <= wrap_d ? '0 : counter_q + 32'd1;
            if (wrap_d) begin
              sq_q <= ~sq_q;
            end
            if (rise_d) begin
              tick_q       <= 1'b1;
              tick_count_q <= tick_count_q + 16'd1;
            end
            if (fall_d) begin
              active_q <= pending_q;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tick       = tick_q;
  assign bus.sq_out     = sq_q;
  assign bus.busy       = (state_q == RUN) || (state_q == STEP);
  assign bus.tick_count = tick_count_q;
  assign bus.state      = state_q;
`ifdef TIMEBASE_BURST_EN
  assign bus.burst_done = burst_done_q;
`endif

endmodule

// File: tb/tb_timebase_controller.sv
// Directed testbench for timebase_controller with CLOCK_FREQ=1000
// (half periods: slow 500, mid 25, fast 1 cycles).
module tb_timebase_controller;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   fails   = 0;

  timebase_controller_if bus();

  timebase_controller #(
    .CLOCK_FREQ(1000),
    .FREQ_SLOW (1),
    .FREQ_MID  (20),
    .FREQ_FAST (500)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Advance n rising edges; returns 1 time unit after the last edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_inputs;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.step     = 1'b0;
    bus.rate_sel = 2'b11;
`ifdef TIMEBASE_BURST_EN
    bus.burst_len = 8'd0;
`endif
  endtask

  // Reset, then hold rate_sel long enough for pending and active to load it
  task automatic apply_reset(input logic [1:0] rate);
    clear_inputs();
    bus.rate_sel = rate;
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
  endtask

  // cmd = {stop, start, step}, asserted for exactly one sampling edge
  task automatic pulse(input logic [2:0] cmd);
    {bus.stop, bus.start, bus.step} = cmd;
    cyc(1);
    {bus.stop, bus.start, bus.step} = 3'b000;
  endtask

  // Edges until tick is seen; -1 if the budget expires
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!bus.tick && n < budget);
    if (!bus.tick) n = -1;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b want 00", bus.state); end
    checks++; if (bus.sq_out !== 1'b0) begin fails++; $display("FAIL reset_sq: got %b want 0", bus.sq_out); end
    checks++; if (bus.tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.tick_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.tick_count); end
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_run_mid;
    int n;
    apply_reset(2'b01);
    pulse(3'b010);
    checks++; if (bus.state !== 2'b01) begin fails++; $display("FAIL run_state: got %b want 01", bus.state); end
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL run_busy: got %b want 1", bus.busy); end
    wait_tick(100, n);
    checks++; if (n !== 25) begin fails++; $display("FAIL run_first_tick: got %0d edges want 25", n); end
    checks++; if (bus.tick_count !== 16'd1) begin fails++; $display("FAIL run_count1: got %0d want 1", bus.tick_count); end
    cyc(150);
    checks++; if (bus.tick !== 1'b1) begin fails++; $display("FAIL run_tick_at_175: got %b want 1", bus.tick); end
    checks++; if (bus.tick_count !== 16'd4) begin fails++; $display("FAIL run_count_175: got %0d want 4", bus.tick_count); end
    wait_tick(100, n);
    checks++; if (n !== 50) begin fails++; $display("FAIL run_period: got %0d edges want 50", n); end
    checks++; if (bus.sq_out !== 1'b1) begin fails++; $display("FAIL run_sq_at_tick: got %b want 1", bus.sq_out); end
    $display("test_run_mid: first tick %0d-edge latency, period 50, count %0d", 25, bus.tick_count);
  endtask

  task automatic test_rate_switch;
    int n;
    apply_reset(2'b10);
    pulse(3'b010);
    wait_tick(10, n);
    checks++; if (n !== 1) begin fails++; $display("FAIL fast_first_tick: got %0d want 1", n); end
    cyc(1);
    checks++; if (bus.sq_out !== 1'b0 || bus.tick !== 1'b0) begin fails++; $display("FAIL fast_low: got sq=%b tick=%b want 0/0", bus.sq_out, bus.tick); end
    cyc(1);
    checks++; if (bus.sq_out !== 1'b1 || bus.tick !== 1'b1) begin fails++; $display("FAIL fast_high: got sq=%b tick=%b want 1/1", bus.sq_out, bus.tick); end
    // Request slow mid-period: pending loads next edge, active switches at the
    // following falling toggle, so one more fast period completes first.
    bus.rate_sel = 2'b00;
    wait_tick(10, n);
    checks++; if (n !== 2) begin fails++; $display("FAIL switch_last_fast: got %0d want 2", n); end
    // One fast low half (1 edge) then a full slow low half (500 edges)
    wait_tick(1200, n);
    checks++; if (n !== 501) begin fails++; $display("FAIL switch_first_slow: got %0d want 501", n); end
    wait_tick(1200, n);
    checks++; if (n !== 1000) begin fails++; $display("FAIL slow_period: got %0d want 1000", n); end
    $display("test_rate_switch: fast->slow applied at period boundary");
  endtask

  task automatic test_pause_resume;
    int n;
    int ticks_seen;
    int sq_seen;
    apply_reset(2'b01);
    pulse(3'b010);
    cyc(10);
    pulse(3'b100);
    checks++; if (bus.state !== 2'b10) begin fails++; $display("FAIL pause_state: got %b want 10", bus.state); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL pause_busy: got %b want 0", bus.busy); end
    ticks_seen = 0;
    sq_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (bus.tick) ticks_seen++;
      if (bus.sq_out) sq_seen++;
    end
    checks++; if (ticks_seen !== 0 || sq_seen !== 0) begin fails++; $display("FAIL pause_frozen: got ticks=%0d sq_high=%0d want 0/0", ticks_seen, sq_seen); end
    checks++; if (bus.state !== 2'b10) begin fails++; $display("FAIL pause_hold: got %b want 10", bus.state); end
    pulse(3'b010);
    checks++; if (bus.state !== 2'b01) begin fails++; $display("FAIL resume_state: got %b want 01", bus.state); end
    wait_tick(100, n);
    checks++; if (n !== 15) begin fails++; $display("FAIL resume_tick: got %0d want 15", n); end
    checks++; if (bus.tick_count !== 16'd1) begin fails++; $display("FAIL resume_count: got %0d want 1", bus.tick_count); end
    $display("test_pause_resume: frozen 100 cycles, resumed after %0d edges", n);
  endtask

  task automatic test_step;
    int n;
    apply_reset(2'b01);
    pulse(3'b001);
    checks++; if (bus.state !== 2'b11 || bus.busy !== 1'b1) begin fails++; $display("FAIL step_enter: got state=%b busy=%b want 11/1", bus.state, bus.busy); end
    wait_tick(100, n);
    checks++; if (n !== 25) begin fails++; $display("FAIL step_tick1: got %0d want 25", n); end
    checks++; if (bus.tick_count !== 16'd1) begin fails++; $display("FAIL step_count1: got %0d want 1", bus.tick_count); end
    cyc(1);
    checks++; if (bus.state !== 2'b10 || bus.sq_out !== 1'b1 || bus.tick !== 1'b0) begin fails++; $display("FAIL step_to_pause: got state=%b sq=%b tick=%b want 10/1/0", bus.state, bus.sq_out, bus.tick); end
    cyc(30);
    checks++; if (bus.sq_out !== 1'b1 || bus.tick_count !== 16'd1) begin fails++; $display("FAIL step_hold: got sq=%b count=%0d want 1/1", bus.sq_out, bus.tick_count); end
    pulse(3'b001);
    wait_tick(200, n);
    checks++; if (n !== 50) begin fails++; $display("FAIL step_tick2: got %0d want 50", n); end
    cyc(1);
    checks++; if (bus.state !== 2'b10 || bus.tick_count !== 16'd2) begin fails++; $display("FAIL step_end2: got state=%b count=%0d want 10/2", bus.state, bus.tick_count); end
    $display("test_step: two single steps, count %0d", bus.tick_count);
  endtask

  task automatic test_priority;
    apply_reset(2'b01);
    pulse(3'b010);
    cyc(5);
    pulse(3'b111);
    checks++; if (bus.state !== 2'b10) begin fails++; $display("FAIL prio_all_in_run: got %b want 10", bus.state); end
    pulse(3'b011);
    checks++; if (bus.state !== 2'b01) begin fails++; $display("FAIL prio_start_over_step: got %b want 01", bus.state); end
    pulse(3'b100);
    pulse(3'b001);
    checks++; if (bus.state !== 2'b11) begin fails++; $display("FAIL prio_step_from_pause: got %b want 11", bus.state); end
    $display("test_priority: stop > start > step");
  endtask

  task automatic test_async_reset;
    int n;
    apply_reset(2'b10);
    pulse(3'b010);
    wait_tick(10, n);
    checks++; if (bus.sq_out !== 1'b1 || bus.tick_count !== 16'd1) begin fails++; $display("FAIL areset_pre: got sq=%b count=%0d want 1/1", bus.sq_out, bus.tick_count); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.state !== 2'b00 || bus.busy !== 1'b0) begin fails++; $display("FAIL areset_state: got state=%b busy=%b want 00/0", bus.state, bus.busy); end
    checks++; if (bus.sq_out !== 1'b0 || bus.tick !== 1'b0 || bus.tick_count !== 16'd0) begin fails++; $display("FAIL areset_outs: got sq=%b tick=%b count=%0d want 0/0/0", bus.sq_out, bus.tick, bus.tick_count); end
    $display("test_async_reset: mid-cycle reset cleared outputs");
  endtask

`ifdef TIMEBASE_BURST_EN
  task automatic test_burst;
    int ticks_seen;
    int done_at;
    int done_cnt;
    apply_reset(2'b10);
    bus.burst_len = 8'd3;
    pulse(3'b010);
    bus.burst_len = 8'd0;
    ticks_seen = 0;
    done_at = -1;
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (bus.tick) ticks_seen++;
      if (bus.burst_done) begin
        done_cnt++;
        done_at = k;
      end
    end
    checks++; if (ticks_seen !== 3) begin fails++; $display("FAIL burst_ticks: got %0d want 3", ticks_seen); end
    checks++; if (done_cnt !== 1 || done_at !== 6) begin fails++; $display("FAIL burst_done: got %0d pulses at edge %0d want 1 at 6", done_cnt, done_at); end
    checks++; if (bus.state !== 2'b00 || bus.sq_out !== 1'b0 || bus.tick_count !== 16'd3) begin fails++; $display("FAIL burst_end: got state=%b sq=%b count=%0d want 00/0/3", bus.state, bus.sq_out, bus.tick_count); end
    $display("test_burst: burst of 3 ticks ended in IDLE");
  endtask
`endif

  initial begin
    test_reset();
    test_run_mid();
    test_rate_switch();
    test_pause_resume();
    test_step();
    test_priority();
    test_async_reset();
`ifdef TIMEBASE_BURST_EN
    test_burst();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
